// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM port arbiter: FSM state, in-flight tag layout,
// and parameter defaults used by the interface and top.
package ram_arb_pkg;

    localparam int DEF_BAND      = 64;
    localparam int DEF_DEPTH     = 1024;
    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_MAX_BURST = 8;
    // Tag index is sized for the largest supported requester count (8).
    localparam int TAG_IW        = 3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOCKED
    } arb_state_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_IW-1:0] idx;
        logic              was_write;
    } arb_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side bus of the arbiter; slave is the arbiter's view,
// master is the view of the requesters plus the RAM they share.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int BAND    = DEF_BAND,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NUM_REQ = DEF_NUM_REQ
);
    localparam int AW = $clog2(DEPTH);

    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0]      we;
    logic [NUM_REQ-1:0]      lock;
    logic [NUM_REQ*AW-1:0]   addr;
    logic [NUM_REQ*BAND-1:0] wdata;
    logic [NUM_REQ-1:0]      gnt;
    logic [NUM_REQ-1:0]      rvalid;
    logic [NUM_REQ-1:0]      wack;
    logic [BAND-1:0]         rdata;

    logic                    mem_wr;
    logic                    mem_rd;
    logic [AW-1:0]           mem_addr;
    logic [BAND-1:0]         mem_wdata;
    logic [BAND-1:0]         mem_rdata;
    logic                    mem_rvalid;
    logic                    mem_wdone;

    modport slave (
        input  req, we, lock, addr, wdata, mem_rdata, mem_rvalid, mem_wdone,
        output gnt, rvalid, wack, rdata, mem_wr, mem_rd, mem_addr, mem_wdata
    );

    modport master (
        output req, we, lock, addr, wdata, mem_rdata, mem_rvalid, mem_wdone,
        input  gnt, rvalid, wack, rdata, mem_wr, mem_rd, mem_addr, mem_wdata
    );

endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr (wrapping) that is
// both requesting and unmasked wins; returns one-hot grant and its index.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin : pick
        int   c;
        logic found;
        // NOTE: every output and local gets a default before the search so no path leaves a latch.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (!found && req[c] && mask[c]) begin
                gnt[c] = 1'b1;
                idx    = IW'(c);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters, with locked bursts
// capped at MAX_BURST. Define RAM_ARB_STATS_EN to add grant_cnt/stall_cnt statistics outputs.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int BAND      = DEF_BAND,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                     clk,
    input  logic                     rst,
    ram_port_arbiter_if.slave        bus
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]    grant_cnt,
    output logic [31:0]              stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t         state, state_nxt;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner, owner_nxt;
    logic [CW-1:0]      burst_cnt, burst_cnt_nxt;
    logic               excl_valid, excl_valid_nxt;
    logic [IW-1:0]      excl_idx, excl_idx_nxt;
    arb_tag_t           tag;

    logic               owner_hold;
    logic [NUM_REQ-1:0] excl_oh;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [IW-1:0]      rr_idx;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [IW-1:0]      gidx;
    logic               any_gnt;
    logic [CW-1:0]      run_len;

    // A forced rotation bars the previous owner for one cycle, but only if someone else wants in.
    always_comb begin
        owner_hold = (state == LOCKED) && bus.req[owner] && bus.lock[owner];
        excl_oh    = NUM_REQ'(1) << excl_idx;
        mask       = '1;
        if (excl_valid && (|(bus.req & ~excl_oh))) mask = ~excl_oh;
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req  (bus.req),
        .mask (mask),
        .ptr  (ptr),
        .gnt  (rr_gnt),
        .idx  (rr_idx)
    );

    always_comb begin
        gidx    = owner_hold ? owner : rr_idx;
        any_gnt = !rst && (owner_hold || (|rr_gnt));
        gnt_vec = '0;
        if (any_gnt) gnt_vec = NUM_REQ'(1) << gidx;
    end

    // Next-state: the grant decided this cycle determines where the FSM and burst count go.
    always_comb begin
        state_nxt      = IDLE;
        owner_nxt      = owner;
        burst_cnt_nxt  = '0;
        excl_valid_nxt = 1'b0;
        excl_idx_nxt   = excl_idx;
        run_len        = CW'(1);
        if (owner_hold)
            run_len = (burst_cnt == CW'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
        if (any_gnt) begin
            state_nxt = GRANT;
            if (bus.lock[gidx]) begin
                if (run_len >= CW'(MAX_BURST)) begin
                    excl_valid_nxt = 1'b1;
                    excl_idx_nxt   = gidx;
                end else begin
                    state_nxt     = LOCKED;
                    owner_nxt     = gidx;
                    burst_cnt_nxt = run_len;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            burst_cnt  <= '0;
            excl_valid <= 1'b0;
            excl_idx   <= '0;
            tag        <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            burst_cnt  <= burst_cnt_nxt;
            excl_valid <= excl_valid_nxt;
            excl_idx   <= excl_idx_nxt;
            if (any_gnt) ptr <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            tag <= '{valid: any_gnt, idx: TAG_IW'(gidx), was_write: bus.we[gidx]};
        end
    end

    // Responses are steered by the tag, so the RAM's sticky data_valid on idle cycles is ignored.
    always_comb begin : outputs
        logic hit;
        bus.gnt       = gnt_vec;
        bus.mem_wr    = any_gnt && bus.we[gidx];
        bus.mem_rd    = any_gnt && !bus.we[gidx];
        bus.mem_addr  = bus.addr[gidx*AW +: AW];
        bus.mem_wdata = bus.wdata[gidx*BAND +: BAND];
        bus.rdata     = bus.mem_rdata;
        bus.rvalid    = '0;
        bus.wack      = '0;
        hit           = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hit           = tag.valid && !rst && (tag.idx == TAG_IW'(i));
            bus.rvalid[i] = hit && bus.mem_rvalid && !tag.was_write;
            bus.wack[i]   = hit && bus.mem_wdone && tag.was_write;
        end
    end

`ifdef RAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (gnt_vec[i]) grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
            if (|(bus.req & ~gnt_vec)) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter against a rule-level reference model
// and a behavioural single-port RAM.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int N     = 2;
    localparam int BAND  = 64;
    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);
    localparam int MAXB  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.BAND(BAND), .DEPTH(DEPTH), .NUM_REQ(N)) bus ();

`ifdef RAM_ARB_STATS_EN
    logic [N*32-1:0] grant_cnt;
    logic [31:0]     stall_cnt;
`endif

    ram_port_arbiter #(
        .BAND(BAND), .DEPTH(DEPTH), .NUM_REQ(N), .MAX_BURST(MAXB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef RAM_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // Behavioural RAM: registered outputs, data_valid stays high once a read has happened.
    logic [BAND-1:0] ram [DEPTH] = '{default: '0};
    logic [BAND-1:0] ram_q       = '0;
    logic            ram_valid   = 1'b0;
    logic            ram_written = 1'b0;
    always @(posedge clk) begin
        ram_written <= bus.mem_wr;
        if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd) begin
            ram_q     <= ram[bus.mem_addr];
            ram_valid <= 1'b1;
        end
    end
    assign bus.mem_rdata  = ram_q;
    assign bus.mem_rvalid = ram_valid;
    assign bus.mem_wdone  = ram_written;

    // Stimulus for the next cycle
    logic            t_rst;
    logic [N-1:0]    t_req, t_we, t_lock;
    logic [AW-1:0]   t_addr  [N];
    logic [BAND-1:0] t_wdata [N];

    // Reference model: last winner, current burst owner and its run length, barred requester
    int              m_last, m_owner, m_run, m_ban;
    bit              p_valid, p_write;
    int              p_idx;
    logic [BAND-1:0] p_data;
    logic [BAND-1:0] mdl_mem [DEPTH] = '{default: '0};
    int unsigned     m_gcnt [N];
    int unsigned     m_stall;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [N-1:0]    obs_gnt;

    function automatic int model_pick();
        bit others;
        int i;
        if (m_owner >= 0 && t_req[m_owner] && t_lock[m_owner]) return m_owner;
        others = 1'b0;
        for (int j = 0; j < N; j++) if (t_req[j] && j != m_ban) others = 1'b1;
        for (int k = 1; k <= N; k++) begin
            i = (m_last + k) % N;
            if (t_req[i] && !(i == m_ban && others)) return i;
        end
        return -1;
    endfunction

    function automatic void model_update(int w);
        int run;
        if (t_rst) begin
            m_last = N - 1; m_owner = -1; m_run = 0; m_ban = -1; p_valid = 1'b0;
            for (int j = 0; j < N; j++) m_gcnt[j] = 0;
            m_stall = 0;
            return;
        end
        if (w >= 0) m_gcnt[w]++;
        for (int j = 0; j < N; j++)
            if (t_req[j] && j != w) begin m_stall++; break; end
        if (w < 0) begin
            m_owner = -1; m_run = 0; m_ban = -1; p_valid = 1'b0;
            return;
        end
        p_valid = 1'b1;
        p_idx   = w;
        p_write = t_we[w];
        if (t_we[w]) mdl_mem[t_addr[w]] = t_wdata[w];
        p_data  = mdl_mem[t_addr[w]];
        m_last  = w;
        m_ban   = -1;
        if (t_lock[w]) begin
            run = (m_owner == w) ? m_run + 1 : 1;
            if (run >= MAXB) begin
                m_ban = w; m_owner = -1; m_run = 0;
            end else begin
                m_owner = w; m_run = run;
            end
        end else begin
            m_owner = -1; m_run = 0;
        end
    endfunction

    task automatic randomize_lanes();
        for (int i = 0; i < N; i++) begin
            t_addr[i]  = AW'($urandom_range(15, 0));
            t_wdata[i] = {$urandom, $urandom};
        end
    endtask

    // One clock: drive at negedge, compare everything against the model, then advance the model.
    task automatic cycle();
        int           w;
        logic [N-1:0] e_gnt, e_rv, e_wa;
        logic         e_wr, e_rd;
        @(negedge clk);
        rst      = t_rst;
        bus.req  = t_req;
        bus.we   = t_we;
        bus.lock = t_lock;
        for (int i = 0; i < N; i++) begin
            bus.addr[i*AW +: AW]      = t_addr[i];
            bus.wdata[i*BAND +: BAND] = t_wdata[i];
        end
        #1;
        e_rv = '0;
        e_wa = '0;
        if (!t_rst && p_valid) begin
            if (p_write) e_wa[p_idx] = 1'b1;
            else         e_rv[p_idx] = 1'b1;
        end
        n_checks++;
        if (bus.rvalid !== e_rv) begin
            n_fail++;
            $display("FAIL rvalid @%0t: got %b expected %b", $time, bus.rvalid, e_rv);
        end
        n_checks++;
        if (bus.wack !== e_wa) begin
            n_fail++;
            $display("FAIL wack @%0t: got %b expected %b", $time, bus.wack, e_wa);
        end
        if (e_rv != '0) begin
            n_checks++;
            if (bus.rdata !== p_data) begin
                n_fail++;
                $display("FAIL rdata @%0t: got %h expected %h", $time, bus.rdata, p_data);
            end
        end
`ifdef RAM_ARB_STATS_EN
        n_checks++;
        if (grant_cnt !== {m_gcnt[1], m_gcnt[0]} || stall_cnt !== m_stall) begin
            n_fail++;
            $display("FAIL stats @%0t: got %h/%0d expected %h/%0d", $time, grant_cnt, stall_cnt,
                     {m_gcnt[1], m_gcnt[0]}, m_stall);
        end
`endif
        w     = t_rst ? -1 : model_pick();
        e_gnt = (w >= 0) ? (N'(1) << w) : '0;
        e_wr  = (w >= 0) ? t_we[w]  : 1'b0;
        e_rd  = (w >= 0) ? !t_we[w] : 1'b0;
        n_checks++;
        if (bus.gnt !== e_gnt) begin
            n_fail++;
            $display("FAIL gnt @%0t: got %b expected %b", $time, bus.gnt, e_gnt);
        end
        n_checks++;
        if ({bus.mem_wr, bus.mem_rd} !== {e_wr, e_rd}) begin
            n_fail++;
            $display("FAIL strobes @%0t: got wr=%b rd=%b expected wr=%b rd=%b", $time,
                     bus.mem_wr, bus.mem_rd, e_wr, e_rd);
        end
        if (w >= 0) begin
            n_checks++;
            if (bus.mem_addr !== t_addr[w] || (e_wr && bus.mem_wdata !== t_wdata[w])) begin
                n_fail++;
                $display("FAIL mem_bus @%0t: got addr %0d data %h expected addr %0d data %h",
                         $time, bus.mem_addr, bus.mem_wdata, t_addr[w], t_wdata[w]);
            end
        end
        obs_gnt = bus.gnt;
        model_update(w);
    endtask

    task automatic set_idle();
        t_rst = 1'b0; t_req = '0; t_we = '0; t_lock = '0;
        randomize_lanes();
    endtask

    task automatic test_reset();
        set_idle();
        t_rst = 1'b1; t_req = 2'b11; t_we = 2'b01;
        repeat (2) cycle();
        set_idle();
        cycle();
    endtask

    task automatic test_fairness();
        set_idle();
        t_req = 2'b11;
        repeat (6) begin
            randomize_lanes();
            cycle();
        end
        set_idle();
        cycle();
    endtask

    task automatic test_write_readback();
        set_idle();
        t_req = 2'b01; t_we = 2'b01; t_addr[0] = AW'(5); t_wdata[0] = 64'hA5;
        cycle();
        set_idle();
        t_req = 2'b10; t_addr[1] = AW'(5);
        cycle();
        set_idle();
        cycle();
        n_checks++;
        if (bus.rvalid !== 2'b10 || bus.rdata !== 64'hA5) begin
            n_fail++;
            $display("FAIL readback: got rvalid %b rdata %h expected 10 / a5", bus.rvalid, bus.rdata);
        end
    endtask

    task automatic test_burst();
        int           g1;
        int           budget;
        logic [N-1:0] seq [$];
        logic [N-1:0] exp_seq [$];
        for (int i = 0; i < 8; i++) exp_seq.push_back(2'b10);
        exp_seq.push_back(2'b01);
        for (int i = 0; i < 4; i++) exp_seq.push_back(2'b10);
        // A lone read by requester 0 moves the round-robin start to requester 1.
        set_idle();
        t_req = 2'b01;
        cycle();
        g1 = 0;
        budget = 0;
        while (g1 < 12 && budget < 40) begin
            set_idle();
            t_req = 2'b11; t_lock = 2'b10;
            cycle();
            seq.push_back(obs_gnt);
            if (obs_gnt == 2'b10) g1++;
            budget++;
        end
        n_checks++;
        if (seq.size() != exp_seq.size()) begin
            n_fail++;
            $display("FAIL burst_len: got %0d beats expected %0d", seq.size(), exp_seq.size());
        end
        for (int i = 0; i < seq.size() && i < exp_seq.size(); i++) begin
            n_checks++;
            if (seq[i] !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL burst_beat %0d: got %b expected %b", i, seq[i], exp_seq[i]);
            end
        end
        set_idle();
        cycle();
    endtask

    task automatic test_idle_and_reset_mid_read();
        set_idle();
        t_req = 2'b01; t_addr[0] = AW'(5);
        cycle();
        set_idle();
        repeat (3) cycle();
        set_idle();
        t_req = 2'b10; t_addr[1] = AW'(5);
        cycle();
        set_idle();
        t_rst = 1'b1;
        cycle();
        set_idle();
        repeat (2) cycle();
    endtask

    task automatic test_stats();
`ifdef RAM_ARB_STATS_EN
        set_idle();
        t_rst = 1'b1;
        cycle();
        set_idle();
        t_req = 2'b11;
        repeat (10) cycle();
        @(posedge clk);
        #1;
        n_checks++;
        if (grant_cnt !== {32'd5, 32'd5} || stall_cnt !== 32'd10) begin
            n_fail++;
            $display("FAIL stats_10: got %h/%0d expected 5,5/10", grant_cnt, stall_cnt);
        end
        set_idle();
        cycle();
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            t_rst  = ($urandom_range(59, 0) == 0);
            t_req  = N'($urandom);
            t_we   = N'($urandom);
            t_lock = ($urandom_range(2, 0) != 0) ? N'($urandom) : '0;
            if ($urandom_range(3, 0) != 0) t_req = t_req | N'(1 << $urandom_range(N - 1, 0));
            randomize_lanes();
            cycle();
        end
        set_idle();
        repeat (2) cycle();
    endtask

    initial begin
        bus.req  = '0;
        bus.we   = '0;
        bus.lock = '0;
        bus.addr = '0;
        bus.wdata = '0;
        m_last = N - 1; m_owner = -1; m_run = 0; m_ban = -1;
        p_valid = 1'b0; p_write = 1'b0; p_idx = 0; p_data = '0;
        for (int j = 0; j < N; j++) m_gcnt[j] = 0;
        m_stall = 0;
        set_idle();
        test_reset();
        test_fairness();
        test_write_readback();
        test_burst();
        test_idle_and_reset_mid_read();
        test_stats();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
